// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3, one bit per clock.
// Feeds per-digit 7-segment decoders; lz_mask supports leading-zero blanking.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     lz_mask,
    output logic                  ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [CW-1:0]     LAST   = CW'(WIDTH - 1);
    localparam logic [DIGITS-1:0] LZ_RST = {DIGITS{1'b1}} << 1;

    logic [0:0]        state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [BW-1:0]     scratch_q, scratch_d;
    logic              sticky_q, sticky_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [DIGITS-1:0] lz_q, lz_d;
    logic              ovf_q, ovf_d;

    logic [BW-1:0]     adj;
    logic [BW-1:0]     scratch_sh;
    logic [WIDTH-1:0]  shreg_sh;
    logic              shift_out;
    logic [DIGITS-1:0] lz_calc;
    logic              all_zero;

    // Add-3 correction per digit, then one-bit shift of {scratch, shreg}.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        shift_out  = adj[BW-1];
        scratch_sh = {adj[BW-2:0], shreg_q[WIDTH-1]};
        shreg_sh   = shreg_q << 1;
    end

    // Leading-zero mask: digit i masked when it and all higher digits are 0.
    always_comb begin
        lz_calc  = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero & (scratch_sh[4*i +: 4] == 4'd0);
            lz_calc[i] = all_zero;
        end
    end

    // Next-state logic: accept in IDLE, shift WIDTH times, publish result.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        lz_d      = lz_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d   = bin;
                    scratch_d = '0;
                    sticky_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scratch_d = scratch_sh;
                shreg_d   = shreg_sh;
                sticky_d  = sticky_q | shift_out;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    bcd_d   = scratch_sh;
                    ovf_d   = sticky_q | shift_out;
                    lz_d    = lz_calc;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; async reset aborts any conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            lz_q      <= LZ_RST;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            lz_q      <= lz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy    = (state_q == S_SHIFT);
    assign done    = done_q;
    assign bcd     = bcd_q;
    assign lz_mask = lz_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: 5-digit and 4-digit instances,
// arithmetic reference model, decoupled driver and done monitors.
module tb_bin2bcd_seq;

    typedef struct {
        logic [19:0] bcd;
        logic [4:0]  lz;
        logic        ovf;
        int          acc;
        int          v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start2;
    logic [15:0] bin, bin2;
    logic        busy, done, ovf;
    logic [19:0] bcd;
    logic [4:0]  lz;
    logic        busy2, done2, ovf2;
    logic [15:0] bcd2;
    logic [3:0]  lz2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    exp_t q1[$];
    exp_t q2[$];
    logic [19:0] last_bcd;
    logic [4:0]  last_lz;
    logic        last_ovf;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .lz_mask(lz), .ovf(ovf)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .lz_mask(lz2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Decimal reference: digits of v mod 10**d, zero-test of high parts.
    function automatic exp_t model(input int v, input int d);
        exp_t r;
        int p, lo, q;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        r.ovf = (v >= p);
        lo    = v % p;
        r.bcd = '0;
        r.lz  = '0;
        q     = lo;
        for (int i = 0; i < d; i++) begin
            if (i > 0) r.lz[i] = (q == 0);
            r.bcd[4*i +: 4] = 4'(q % 10);
            q = q / 10;
        end
        r.v   = v;
        r.acc = 0;
        return r;
    endfunction

    task automatic issue(input int sel, input int v);
        exp_t e;
        int   ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((sel == 0 && !busy) || (sel == 1 && !busy2)) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy stuck 1, required 0");
            return;
        end
        if (sel == 0) begin bin = 16'(v); start = 1'b1; end
        else begin bin2 = 16'(v); start2 = 1'b1; end
        @(posedge clk);
        #1;
        start  = 1'b0;
        start2 = 1'b0;
        e      = model(v, sel == 0 ? 5 : 4);
        e.acc  = cyc;
        if (sel == 0) q1.push_back(e);
        else q2.push_back(e);
    endtask

    // Monitor for the 5-digit instance, plus output-hold checking.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_bcd = bcd;
            last_lz  = lz;
            last_ovf = ovf;
        end else if (done) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 required 0");
            end else begin
                e = q1.pop_front();
                chk($sformatf("bcd(%0d)", e.v), 32'(bcd), 32'(e.bcd));
                chk($sformatf("lz(%0d)", e.v), 32'(lz), 32'(e.lz));
                chk($sformatf("ovf(%0d)", e.v), 32'(ovf), 32'(e.ovf));
                chk($sformatf("latency(%0d)", e.v), 32'(cyc - e.acc), 32'd16);
            end
            last_bcd = bcd;
            last_lz  = lz;
            last_ovf = ovf;
        end else begin
            chk("hold", {11'd0, last_ovf, last_lz, bcd == last_bcd},
                {11'd0, ovf, lz, 1'b1});
        end
    end

    // Monitor for the 4-digit instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done2) begin
            if (q2.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done4: got done=1 required 0");
            end else begin
                e = q2.pop_front();
                chk($sformatf("bcd4(%0d)", e.v), 32'(bcd2), 32'(e.bcd[15:0]));
                chk($sformatf("lz4(%0d)", e.v), 32'(lz2), 32'(e.lz[3:0]));
                chk($sformatf("ovf4(%0d)", e.v), 32'(ovf2), 32'(e.ovf));
                chk($sformatf("latency4(%0d)", e.v), 32'(cyc - e.acc), 32'd16);
            end
        end
    end

    initial begin
        int ok;
        int w;
        exp_t e;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        bin    = '0;
        bin2   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_lz", 32'(lz), 32'h1e);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_lz4", 32'(lz2), 32'he);
        rst_n = 1'b1;

        issue(0, 0);
        issue(0, 65535);
        issue(0, 1234);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            start = (k == 3 || k == 8);
            chk("busy_during", 32'(busy), 32'd1);
        end
        start = 1'b0;

        // Back-to-back: start held through the done cycle.
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        chk("b2b_idle", 32'(ok), 32'd1);
        bin   = 16'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        e     = model(7, 5);
        e.acc = cyc;
        q1.push_back(e);
        bin = 16'd42;
        ok  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        chk("b2b_done_seen", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        e     = model(42, 5);
        e.acc = cyc;
        q1.push_back(e);

        for (int i = 0; i < 40; i++) begin
            w = $urandom_range(1, 16);
            issue(0, int'($urandom_range(0, (1 << w) - 1)));
        end

        // Reset in the middle of a conversion.
        issue(0, 500);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        q1.delete();
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd", 32'(bcd), 32'd0);
        chk("abort_lz", 32'(lz), 32'h1e);
        chk("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(0, 500);

        issue(1, 12345);
        issue(1, 9999);
        issue(1, 10000);
        issue(1, 0);
        for (int i = 0; i < 20; i++)
            issue(1, int'($urandom_range(0, 65535)));

        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q1.size() == 0 && q2.size() == 0) begin ok = 1; break; end
        end
        chk("drain", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
